sgpr_copy_ctrl: RTL and testbench
=================================

Name: sgpr_copy_ctrl

Overview:
- Sequencer that copies the architectural register file of a healthy core's sgpr (source) into a recovering core's sgpr (destination) during fault recovery.
- Drives the source read port A, registers the data, and drives the destination write port.
- In normal operation it passes the owning core's write port straight through to the destination sgpr.
- During a copy it blocks core writes and stalls the core.

Parameters:
ADDR_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width
FIRST_REG, 1, first register copied (x0 skipped)
LAST_REG, 31, last register copied; FIRST_REG <= LAST_REG < 2**ADDR_WIDTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  request copy; sampled in IDLE only
busy_o  out  1  copy sequence in progress
done_o  out  1  one-cycle pulse, sequence complete
stall_o  out  1  core must hold its write; equals busy_o
mismatch_o  out  1  sticky verify failure (see Optional Feature)
core_we_i  in  1  core write enable
core_waddr_i  in  ADDR_WIDTH  core write address
core_wdata_i  in  DATA_WIDTH  core write data
src_raddr_o  out  ADDR_WIDTH  source sgpr read port A address
src_rdata_i  in  DATA_WIDTH  source sgpr read port A data (combinational read)
dst_raddr_o  out  ADDR_WIDTH  destination sgpr read port B address
dst_rdata_i  in  DATA_WIDTH  destination sgpr read port B data
dst_we_o  out  1  destination write enable
dst_waddr_o  out  ADDR_WIDTH  destination write address
dst_wdata_o  out  DATA_WIDTH  destination write data

Behaviour:
- Reset: asynchronous on rst_n low.
  - State IDLE; counter, pipeline registers, valid_q, mismatch_q all cleared.
  - busy_o=0, done_o=0, stall_o=0, mismatch_o=0.
  - src_raddr_o=0, dst_raddr_o=0.
  - dst_* follow the core passthrough, so dst_we_o=core_we_i.
- States: IDLE, COPY, DRAIN, VERIFY, DONE.
- IDLE:
  - dst_we_o/waddr/wdata = core_we_i/waddr/wdata, combinational passthrough.
  - start_i=1 at a rising edge -> COPY with cnt=FIRST_REG.
  - A core write in the same cycle as start_i still passes through.
- COPY:
  - src_raddr_o=cnt.
  - Each edge captures addr_q=cnt, data_q=src_rdata_i, valid_q=1, then cnt++.
  - dst_we_o=valid_q, dst_waddr_o=addr_q, dst_wdata_o=data_q. Each write lands one cycle after its read (latency 1).
  - When cnt==LAST_REG at an edge -> DRAIN.
- DRAIN:
  - Writes the final register (valid_q=1).
  - valid_q cleared at the exit edge.
  - Next state: VERIFY if the feature is enabled, else DONE.
- VERIFY: see Optional Feature.
- DONE: done_o=1 for exactly one cycle, dst_we_o=0, then IDLE.
- busy_o=stall_o=1 in COPY, DRAIN, VERIFY and DONE. Core writes in these states are dropped, not queued; the core must hold until stall_o falls.
- start_i outside IDLE is ignored.
- start_i high in the DONE cycle is ignored. A new copy needs start_i high in IDLE.
- Without verify, start sampled at edge E: first destination write at E+2, DRAIN write at E+N+1, done_o high in cycle E+N+2, with N=LAST_REG-FIRST_REG+1.
- Counter holds ADDR_WIDTH bits. LAST_REG=2**ADDR_WIDTH-1 must not wrap before DRAIN; compare before increment.
- mismatch_o is cleared when a new copy starts (IDLE->COPY).
- Reset mid-operation aborts immediately. Partially copied destination contents remain; no done_o pulse.

Optional Feature:
- Macro: SGPR_COPY_VERIFY_EN.
- Defined:
  - After DRAIN, enter VERIFY with cnt=FIRST_REG.
  - Each cycle src_raddr_o=dst_raddr_o=cnt, and src_rdata_i is compared with dst_rdata_i. Inequality sets the sticky mismatch_q.
  - Exit to DONE after cnt==LAST_REG, adding N cycles.
  - dst_we_o=0 throughout VERIFY.
- Undefined:
  - VERIFY state is unreachable; DRAIN goes directly to DONE.
  - mismatch_o tied 0; dst_raddr_o tied 0.

Test Plan:
- Preload source x1..x31 = 0x100+i; pulse start_i with defaults -> destination x1..x31 = 0x100+i and x0 untouched; done_o is a single pulse at E+33 (verify off) or E+64 (verify on); mismatch_o=0.
- core_we_i=1, waddr=10, wdata=100 while IDLE -> dst_we_o=1 that cycle and destination x10=100. Same write issued during COPY -> dropped, stall_o=1, x10 holds the copied value.
- start_i and a core write (x5=0xAA) in the same IDLE cycle -> x5=0xAA first, then overwritten by the copy with source x5.
- start_i pulsed again mid-COPY and in the DONE cycle -> no restart; exactly 31 destination writes total; one done_o.
- rst_n low at the 10th COPY cycle -> busy_o, done_o and dst_we_o drop immediately; x1..x9 copied, x10..x31 unchanged; a later start performs a full copy.
- With SGPR_COPY_VERIFY_EN, force destination x7 stuck at 0 -> mismatch_o=1 after the VERIFY cycle for address 7, held through DONE; cleared on the next start.

Source files
------------

// File: rtl/sgpr_copy_ctrl.sv
// sgpr_copy_ctrl: copies a healthy core's scalar register file (source) into a
// recovering core's register file (destination), stalling the owning core
// while the copy runs and passing its writes straight through otherwise.
// Optional read-back verify pass: define SGPR_COPY_VERIFY_EN.
module sgpr_copy_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIRST_REG  = 1,
    parameter int LAST_REG   = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  stall_o,
    output logic                  mismatch_o,
    input  logic                  core_we_i,
    input  logic [ADDR_WIDTH-1:0] core_waddr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    output logic [ADDR_WIDTH-1:0] src_raddr_o,
    input  logic [DATA_WIDTH-1:0] src_rdata_i,
    output logic [ADDR_WIDTH-1:0] dst_raddr_o,
    input  logic [DATA_WIDTH-1:0] dst_rdata_i,
    output logic                  dst_we_o,
    output logic [ADDR_WIDTH-1:0] dst_waddr_o,
    output logic [DATA_WIDTH-1:0] dst_wdata_o
);

`ifdef SGPR_COPY_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    localparam logic [ADDR_WIDTH-1:0] FIRST_A = ADDR_WIDTH'(FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(LAST_REG);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COPY   = 3'd1,
        DRAIN  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    mismatch_q, mismatch_d;

    // Next-state logic: the counter is compared before incrementing so that a
    // last register at the top of the address space never wraps.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        mismatch_d = mismatch_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start_i) begin
                    state_d    = COPY;
                    cnt_d      = FIRST_A;
                    mismatch_d = 1'b0;
                end
            end
            COPY: begin
                addr_d  = cnt_q;
                data_d  = src_rdata_i;
                valid_d = 1'b1;
                if (cnt_q == LAST_A) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                valid_d = 1'b0;
                if (VERIFY_EN) begin
                    state_d = VERIFY;
                    cnt_d   = FIRST_A;
                end else begin
                    state_d = DONE;
                end
            end
            VERIFY: begin
                if (src_rdata_i != dst_rdata_i) begin
                    mismatch_d = 1'b1;
                end
                if (cnt_q == LAST_A) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and read-to-write pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Output decode: core passthrough in IDLE, pipelined copy writes otherwise.
    always_comb begin
        busy_o      = (state_q != IDLE);
        stall_o     = (state_q != IDLE);
        done_o      = (state_q == DONE);
        mismatch_o  = mismatch_q & VERIFY_EN;
        src_raddr_o = '0;
        dst_raddr_o = '0;
        dst_we_o    = 1'b0;
        dst_waddr_o = addr_q;
        dst_wdata_o = data_q;
        case (state_q)
            IDLE: begin
                dst_we_o    = core_we_i;
                dst_waddr_o = core_waddr_i;
                dst_wdata_o = core_wdata_i;
            end
            COPY, DRAIN: begin
                dst_we_o    = valid_q;
                src_raddr_o = (state_q == COPY) ? cnt_q : '0;
            end
            VERIFY: begin
                src_raddr_o = cnt_q;
                dst_raddr_o = VERIFY_EN ? cnt_q : '0;
            end
            default: begin
                dst_we_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sgpr_copy_ctrl.sv
// tb_sgpr_copy_ctrl: randomized self-checking bench for sgpr_copy_ctrl.
// Source and destination register files are modelled as arrays; the expected
// destination image is tracked separately from the rules of the copy.
module tb_sgpr_copy_ctrl;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int FIRST = 1;
    localparam int LAST  = 31;
    localparam int N     = LAST - FIRST + 1;
`ifdef SGPR_COPY_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam int EXP_DONE = VER ? (2 * N + 2) : (N + 2);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, stall, mismatch;
    logic          core_we;
    logic [AW-1:0] core_waddr;
    logic [DW-1:0] core_wdata;
    logic [AW-1:0] src_raddr, dst_raddr, dst_waddr;
    logic [DW-1:0] src_rdata, dst_rdata, dst_wdata;
    logic          dst_we;

    logic [DW-1:0] src_mem [32];
    logic [DW-1:0] dst_mem [32];
    logic [DW-1:0] exp_dst [32];
    bit            stuck7 = 1'b0;
    int            writeCount = 0;
    int            errors = 0;
    int            checks = 0;

    sgpr_copy_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIRST_REG(FIRST), .LAST_REG(LAST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .busy_o(busy), .done_o(done), .stall_o(stall), .mismatch_o(mismatch),
        .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
        .src_raddr_o(src_raddr), .src_rdata_i(src_rdata),
        .dst_raddr_o(dst_raddr), .dst_rdata_i(dst_rdata),
        .dst_we_o(dst_we), .dst_waddr_o(dst_waddr), .dst_wdata_o(dst_wdata)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Combinational read ports of both register files; x7 can be forced to read 0.
    assign src_rdata = src_mem[src_raddr];
    assign dst_rdata = (stuck7 && dst_raddr == 5'd7) ? '0 : dst_mem[dst_raddr];

    // Destination register file write port; a stuck x7 ignores writes.
    always @(posedge clk) begin
        if (dst_we && !(stuck7 && dst_waddr == 5'd7)) begin
            dst_mem[dst_waddr] <= dst_wdata;
        end
    end

    // Count destination writes issued while the sequencer is busy.
    always @(posedge clk) begin
        if (busy && dst_we) begin
            writeCount <= writeCount + 1;
        end
    end

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // The stall output must always track busy, checked away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checkOutput("stall_eq_busy", stall, busy);
        end
    end

    // Advance one clock edge and settle just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive the request and core write port together.
    task automatic applyStimulus(input logic st, input logic we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
        start      = st;
        core_we    = we;
        core_waddr = a;
        core_wdata = d;
    endtask

    // One core write while idle: it must appear on the destination port at once.
    task automatic idleWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        applyStimulus(1'b0, 1'b1, a, d);
        #1;
        checkOutput("pass_we", dst_we, 1'b1);
        checkOutput("pass_waddr", dst_waddr, a);
        checkOutput("pass_wdata", dst_wdata, d);
        tick;
        exp_dst[a] = d;
        applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    // Compare the whole destination file against the expected image.
    task automatic checkContents(input string tag);
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("%s_x%0d", tag, i), dst_mem[i], exp_dst[i]);
        end
    endtask

    // A full copy: optional same-cycle core write with the start, optional
    // random core writes and start pokes while busy, plus a start in DONE.
    task automatic runCopy(input logic sWe, input logic [AW-1:0] sA, input logic [DW-1:0] sD,
                           input bit noise);
        int  base;
        int  doneCycle;
        int  pulses;
        int  misFirst;
        int  expMisFirst;
        bit  finished;
        base = writeCount;
        applyStimulus(1'b1, sWe, sA, sD);
        tick;
        if (sWe) begin
            checkOutput("start_cycle_write", dst_mem[sA], sD);
            exp_dst[sA] = sD;
        end
        checkOutput("busy_after_start", busy, 1'b1);
        checkOutput("mismatch_cleared", mismatch, 1'b0);
        doneCycle = 0;
        pulses    = 0;
        misFirst  = 0;
        finished  = 1'b0;
        for (int k = 1; k <= EXP_DONE + 8; k++) begin
            if (!finished) begin
                if (noise) begin
                    applyStimulus((pulses > 0) || ($urandom_range(0, 3) == 0),
                                  1'($urandom_range(0, 1)), AW'($urandom), $urandom);
                end else begin
                    applyStimulus(pulses > 0, 1'b0, '0, '0);
                end
                tick;
                if (done) begin
                    pulses++;
                    if (doneCycle == 0) doneCycle = k + 1;
                    checkOutput("we_in_done", dst_we, 1'b0);
                    checkOutput("mismatch_at_done", mismatch, stuck7);
                end
                if (mismatch && misFirst == 0) misFirst = k;
                if (!busy) finished = 1'b1;
            end
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("copy_finished", finished, 1'b1);
        checkOutput("done_cycle", doneCycle, EXP_DONE);
        checkOutput("done_pulses", pulses, 1);
        checkOutput("copy_writes", writeCount - base, N);
        expMisFirst = stuck7 ? (N + 1 + 7 - FIRST + 1) : 0;
        checkOutput("mismatch_first", misFirst, expMisFirst);
        for (int i = FIRST; i <= LAST; i++) begin
            if (!(stuck7 && i == 7)) exp_dst[i] = src_mem[i];
        end
        checkContents("copy");
    endtask

    // Main sequence: reset, idle passthrough, several copies, abort by reset.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h1234_5678);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_mismatch", mismatch, 1'b0);
        checkOutput("rst_src_raddr", src_raddr, 5'd0);
        checkOutput("rst_dst_raddr", dst_raddr, 5'd0);
        checkOutput("rst_dst_we", dst_we, 1'b1);
        checkOutput("rst_dst_waddr", dst_waddr, 5'd3);
        checkOutput("rst_dst_wdata", dst_wdata, 32'h1234_5678);
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // Source image per the recovery scenario; x0 must never be copied.
        src_mem[0] = 32'hDEAD_BEEF;
        for (int i = 1; i < 32; i++) src_mem[i] = 32'h100 + i;
        for (int i = 0; i < 32; i++) idleWrite(AW'(i), 32'hC300_0000 | ($urandom & 32'hFFFF));
        idleWrite(5'd10, 32'd100);

        $display("[TB] plain copy");
        runCopy(1'b0, '0, '0, 1'b0);

        $display("[TB] copy with core writes and start pokes while busy");
        for (int i = 1; i < 32; i++) src_mem[i] = $urandom;
        runCopy(1'b0, '0, '0, 1'b1);

        $display("[TB] start together with a core write to x5");
        for (int i = 1; i < 32; i++) src_mem[i] = $urandom;
        runCopy(1'b1, 5'd5, 32'hAA, 1'b0);

        $display("[TB] reset in the middle of a copy");
        for (int i = 1; i < 32; i++) src_mem[i] = 32'h5A00_0000 | ($urandom & 32'hFFFFFF);
        applyStimulus(1'b1, 1'b0, '0, '0);
        tick;
        applyStimulus(1'b0, 1'b0, '0, '0);
        repeat (10) tick;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_dst_we", dst_we, 1'b0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        for (int i = 1; i <= 9; i++) exp_dst[i] = src_mem[i];
        checkContents("abort");

        $display("[TB] full copy after abort");
        runCopy(1'b0, '0, '0, 1'b1);

`ifdef SGPR_COPY_VERIFY_EN
        $display("[TB] verify with destination x7 stuck at zero");
        for (int i = 1; i < 32; i++) src_mem[i] = 32'h100 + i;
        stuck7 = 1'b1;
        runCopy(1'b0, '0, '0, 1'b0);
        checkOutput("mismatch_held", mismatch, 1'b1);
        stuck7 = 1'b0;
        runCopy(1'b0, '0, '0, 1'b0);
        checkOutput("mismatch_clear_after", mismatch, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends even if the sequencer hangs.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
